dma_arbiter: RTL
================

# dma_arbiter

Parametrised N-channel arbiter that multiplexes several device DMA masters (monitor, keyboard, clock, future peripherals) onto the single device-side port (port b) of the dual-port system RAM, in the DMA clock domain. It replaces the current single hard-wired device connection. It provides per-channel request/grant handshakes, round-robin or fixed-priority selection, bounded burst locking, and read-data return steered to the issuing channel.

## Interface
- CHANNELS, 4: number of device channels (2..8).
- ADDR_W, 16: RAM word-address width.
- DATA_W, 16: RAM word width.
- RD_LATENCY, 1: cycles from RAM sampling `RAM_addr` to valid `RAM_q` (1..3).
- PRIORITY_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- MAX_BURST, 16: maximum consecutive locked grants to one channel (1..255).

Ports:
- DMA_CLOCK  in  1  sole clock; all state on rising edge.
- RESET_N  in  1  reset, asynchronous and active-low.
- REQ  in  CHANNELS  per-channel access request.
- WE  in  CHANNELS  per-channel write enable (1 = write, 0 = read).
- LOCK  in  CHANNELS  per-channel burst lock request.
- ADDR  in  CHANNELS*ADDR_W  flattened addresses; channel i at [i*ADDR_W +: ADDR_W].
- WDATA  in  CHANNELS*DATA_W  flattened write data, same packing.
- GNT  out  CHANNELS  one-hot combinational grant; the request is accepted at this edge.
- RVALID  out  CHANNELS  one-hot read-return strobe.
- RDATA  out  DATA_W  read data, valid when any RVALID is high (= RAM_q).
- RAM_addr  out  ADDR_W  to RAM port b address.
- RAM_data  out  DATA_W  to RAM port b data.
- RAM_wren  out  1  to RAM port b write enable.
- RAM_q  in  DATA_W  from RAM port b output.

## Operation
- Requester holds REQ/WE/ADDR/WDATA stable until it samples GNT high. It may present a new request in the next cycle.
- Each cycle, at most one GNT bit is high, and only for a channel with REQ high. GNT is all-zero when no REQ is high.
- Round-robin: search starts at (last_granted+1) mod CHANNELS and wraps. Fixed priority: lowest set REQ index wins.
- Lock:
  - If the previous grant went to channel k, and LOCK[k] and REQ[k] are both high, channel k wins again, overriding the mode.
  - burst_cnt counts consecutive locked grants. When it reaches MAX_BURST, the lock is ignored for one arbitration: normal selection runs and k is excluded if any other REQ is high.
  - burst_cnt resets to 0 on any non-lock grant.
- On a granted edge: RAM_addr, RAM_data and RAM_wren are registered from the winner's ADDR, WDATA and WE. On an edge with no grant: RAM_wren <= 0 and RAM_addr/RAM_data hold.
- Reads: a tag {valid, channel id} enters a shift pipeline of depth 1+RD_LATENCY. RVALID[id] is asserted when the tag emerges. RDATA = RAM_q combinationally.
- Writes produce no RVALID.
- last_granted updates only on edges where a grant occurs.

## Timing
- Reset values (asynchronous, while RESET_N low):
  - RAM_wren=0, RAM_addr=0, RAM_data=0.
  - Pipeline tags cleared, so RVALID=0.
  - last_granted=CHANNELS-1, so channel 0 is first; burst_cnt=0.
- GNT has zero latency (combinational from REQ, LOCK, state). RAM port signals are valid one cycle after the grant cycle.
- Read latency: grant in cycle n → RVALID/RDATA in cycle n+1+RD_LATENCY (n+2 by default). Throughput is one access per cycle. Returns arrive in grant order.
- Read-after-write to the same address on consecutive grants returns the new data (port b write completes before the next sampled address).
- Reset asserted mid-operation: all outstanding read tags are discarded and no RVALID is emitted for them. Arbitration restarts at channel 0.
- REQ dropped without grant: no effect on state.

## Test plan
- Single read: RAM[0x1234]=0xBEEF; channel 0 raises REQ with WE=0 and ADDR=0x1234 in cycle 0 → GNT=4'b0001 in cycle 0; RAM_addr=0x1234, RAM_wren=0 in cycle 1; RVALID=4'b0001 with RDATA=0xBEEF in cycle 2.
- Round-robin fairness: all four channels hold REQ for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Each RVALID appears 2 cycles after its grant with the correct channel bit.
- Write/read-back: channel 2 writes 0x5A5A to 0x0010, then reads 0x0010 in the next cycle → RAM_wren=1 in cycle 1, and RVALID[2] with RDATA=0x5A5A in cycle 3.
- Burst lock with MAX_BURST=4: channel 1 holds REQ+LOCK while channel 2 holds REQ → grants 1,1,1,1,2,1,1,1,1,2.
- Fixed priority (PRIORITY_MODE=1): REQ=4'b1110 constantly → channel 1 is always granted and channels 2 and 3 are never granted.
- Reset mid-read: grant a read in cycle 0, pull RESET_N low in cycle 1 → RVALID stays 0 and RAM_wren=0 immediately. After release, REQ=4'b1111 yields first grant to channel 0.

Source files
------------

// File: rtl/dma_arbiter_if.sv
// Device-side DMA bus of the arbiter: per-channel request/grant/return
// signals plus the RAM port b connection. Channel vectors are flattened,
// channel i at [i*W +: W].
interface dma_arbiter_if #(
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16
);
   logic [CHANNELS-1:0]        REQ;
   logic [CHANNELS-1:0]        WE;
   logic [CHANNELS-1:0]        LOCK;
   logic [CHANNELS*ADDR_W-1:0] ADDR;
   logic [CHANNELS*DATA_W-1:0] WDATA;
   logic [CHANNELS-1:0]        GNT;
   logic [CHANNELS-1:0]        RVALID;
   logic [DATA_W-1:0]          RDATA;
   logic [ADDR_W-1:0]          RAM_addr;
   logic [DATA_W-1:0]          RAM_data;
   logic                       RAM_wren;
   logic [DATA_W-1:0]          RAM_q;

   // arbiter side
   modport slave (
      input  REQ, WE, LOCK, ADDR, WDATA, RAM_q,
      output GNT, RVALID, RDATA, RAM_addr, RAM_data, RAM_wren
   );

   // device masters + RAM side
   modport master (
      output REQ, WE, LOCK, ADDR, WDATA, RAM_q,
      input  GNT, RVALID, RDATA, RAM_addr, RAM_data, RAM_wren
   );
endinterface

// File: rtl/dma_arbiter.sv
// N-channel arbiter multiplexing device DMA masters onto RAM port b.
// Zero-latency grant (round-robin or fixed priority) with bounded burst
// locking; read returns are steered back to the issuing channel through
// a tag pipeline matched to the RAM read latency.
module dma_arbiter #(
   parameter int CHANNELS      = 4,
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 16,
   parameter int RD_LATENCY    = 1,
   parameter int PRIORITY_MODE = 0,
   parameter int MAX_BURST     = 16
) (
   input  logic         DMA_CLOCK,
   input  logic         RESET_N,
   dma_arbiter_if.slave bus
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   // read-return tag: travels with each accepted read until RAM_q is valid
   typedef struct packed {
      logic            vld;
      logic [CH_W-1:0] id;
   } tag_t;

   logic [CHANNELS-1:0][ADDR_W-1:0] addr_v;
   logic [CHANNELS-1:0][DATA_W-1:0] wdata_v;

   logic [CH_W-1:0]     last_granted;
   logic                prev_vld;
   logic [7:0]          burst_cnt;

   logic [CHANNELS-1:0] last_oh;
   logic                lock_hold;
   logic                lock_win;
   logic [CHANNELS-1:0] cand;
   logic [CH_W-1:0]     win;
   logic                win_vld;
   logic [CHANNELS-1:0] gnt;
   int                  rr_idx;

   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_data;
   logic                ram_wren;

   tag_t                vld_pipe [RD_LATENCY:0];
   logic [CHANNELS-1:0] rvalid;

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_unpack
         assign addr_v[g]  = bus.ADDR[g*ADDR_W +: ADDR_W];
         assign wdata_v[g] = bus.WDATA[g*DATA_W +: DATA_W];
      end
   endgenerate

   // winner selection: lock override first, then round-robin or fixed priority
   always_comb begin
      last_oh               = '0;
      last_oh[last_granted] = 1'b1;
      // the previous winner still wants the bus and asks to keep it
      lock_hold = prev_vld & bus.REQ[last_granted] & bus.LOCK[last_granted];
      lock_win  = lock_hold && (int'(burst_cnt) < MAX_BURST);
      // burst exhausted: the holder sits this round out if anyone else waits
      cand = bus.REQ;
      if (lock_hold && !lock_win && ((bus.REQ & ~last_oh) != '0))
         cand = bus.REQ & ~last_oh;
      win     = last_granted;
      win_vld = 1'b0;
      rr_idx  = 0;
      if (lock_win) begin
         win_vld = 1'b1;
      end else if (PRIORITY_MODE == 1) begin
         // descending scan so the lowest requesting index is assigned last
         for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (cand[CH_W'(i)]) begin
               win     = CH_W'(i);
               win_vld = 1'b1;
            end
         end
      end else begin
         // scan starts just after the last winner and wraps
         for (int i = 1; i <= CHANNELS; i++) begin
            rr_idx = (int'(last_granted) + i) % CHANNELS;
            if (!win_vld && cand[CH_W'(rr_idx)]) begin
               win     = CH_W'(rr_idx);
               win_vld = 1'b1;
            end
         end
      end
      gnt = '0;
      if (win_vld)
         gnt[win] = 1'b1;
   end

   // arbitration history: last winner and length of the current locked burst
   always_ff @(posedge DMA_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         last_granted <= CH_W'(CHANNELS - 1);
         prev_vld     <= 1'b0;
         burst_cnt    <= 8'd0;
      end else if (win_vld) begin
         last_granted <= win;
         prev_vld     <= 1'b1;
         // a locked grant that was not an override starts a new burst at 1
         if (!bus.LOCK[win])
            burst_cnt <= 8'd0;
         else if (lock_win)
            burst_cnt <= burst_cnt + 8'd1;
         else
            burst_cnt <= 8'd1;
      end
   end

   // RAM port b registers: load from the winner, address/data hold when idle
   always_ff @(posedge DMA_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         ram_addr <= '0;
         ram_data <= '0;
         ram_wren <= 1'b0;
      end else if (win_vld) begin
         ram_addr <= addr_v[win];
         ram_data <= wdata_v[win];
         ram_wren <= bus.WE[win];
      end else begin
         ram_wren <= 1'b0;
      end
   end

   // read tag pipeline: one stage for the address register plus RAM latency
   always_ff @(posedge DMA_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i <= RD_LATENCY; i++)
            vld_pipe[i] <= '0;
      end else begin
         vld_pipe[0] <= '{vld: win_vld & ~bus.WE[win], id: win};
         for (int i = 1; i <= RD_LATENCY; i++)
            vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // return strobe for the channel whose tag emerges this cycle
   always_comb begin
      rvalid = '0;
      if (vld_pipe[RD_LATENCY].vld)
         rvalid[vld_pipe[RD_LATENCY].id] = 1'b1;
   end

   assign bus.GNT      = gnt;
   assign bus.RVALID   = rvalid;
   assign bus.RDATA    = bus.RAM_q;
   assign bus.RAM_addr = ram_addr;
   assign bus.RAM_data = ram_data;
   assign bus.RAM_wren = ram_wren;
endmodule
